irq_ctrl: RTL and testbench

- Memory-mapped interrupt controller on the picoRV peripheral bus.
- Collects one-cycle or level IRQ pulses from peripherals (systick, uart, gpio, ...) and latches them as pending.
- Prioritises enabled pending sources (lowest index wins) and drives a single level IRQ to the CPU.
- Sequences service through a claim/complete handshake, so only one source is in service at a time.

---
 rtl/irq_ctrl_pkg.sv | 27 ++
 rtl/irq_ctrl_if.sv | 21 ++
 rtl/irq_prio_enc.sv | 35 +++
 rtl/irq_ctrl.sv | 126 ++++++++++++
 tb/tb_irq_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants, state encoding and read-word helper for the interrupt controller.
package irq_ctrl_pkg;

    localparam int DATA_W          = 32;
    localparam int ID_W            = 5;
    localparam int CLAIM_VALID_BIT = 31;

    localparam logic [3:0] REG_ENABLE   = 4'h0;
    localparam logic [3:0] REG_PENDING  = 4'h4;
    localparam logic [3:0] REG_CLAIM    = 4'h8;
    localparam logic [3:0] REG_COMPLETE = 4'hC;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    // Builds the {flag, zeros, id} word returned by CLAIM and COMPLETE reads.
    function automatic logic [DATA_W-1:0] id_word(input logic flag, input logic [ID_W-1:0] id);
        logic [DATA_W-1:0] word;
        word                  = '0;
        word[CLAIM_VALID_BIT] = flag;
        word[ID_W-1:0]        = id;
        return word;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// picoRV-style peripheral bus seen by the interrupt controller.
interface irq_ctrl_if;

    logic                              select;
    logic [3:0]                        wstrb;
    logic [3:0]                        addr;
    logic [irq_ctrl_pkg::DATA_W-1:0]   data_i;
    logic                              ready;
    logic [irq_ctrl_pkg::DATA_W-1:0]   data_o;

    modport master (
        output select, wstrb, addr, data_i,
        input  ready, data_o
    );

    modport slave (
        input  select, wstrb, addr, data_i,
        output ready, data_o
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and which one wins.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]    i_req,
    output logic            o_hit,
    output logic [ID_W-1:0] o_best
);

    // w_seen[i] is set when any request below index i is active.
    logic [N:0]   w_seen;
    logic [N-1:0] w_first;

    assign w_seen[0] = 1'b0;

    for (genvar gi = 0; gi < N; gi++) begin : g_chain
        assign w_seen[gi+1] = w_seen[gi] | i_req[gi];
        assign w_first[gi]  = i_req[gi] & ~w_seen[gi];
    end

    assign o_hit = w_seen[N];

    // w_first is one-hot (or zero), so OR-ing the indices of its set bits yields the winner.
    always_comb begin
        o_best = '0;
        for (int i = 0; i < N; i++) begin
            if (w_first[i]) begin
                o_best = o_best | ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge capture, enable mask, priority pick and claim/complete sequencing.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    irq_ctrl_if.slave          bus,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic               cpu_irq
);

    state_t              r_state;
    logic                r_ready;
    logic [DATA_W-1:0]   r_data_o;
    logic [NUM_IRQ-1:0]  r_enable;
    logic [NUM_IRQ-1:0]  r_pending;
    logic [NUM_IRQ-1:0]  r_src_q;
    logic [ID_W-1:0]     r_active_id;
    logic                r_cpu_irq;

    logic                w_accept;
    logic                w_wr;
    logic                w_rd;
    logic                w_hit;
    logic [ID_W-1:0]     w_best;
    logic                w_claim;
    logic                w_complete;
    logic [NUM_IRQ-1:0]  w_edge;
    logic [NUM_IRQ-1:0]  w_w1c;
    logic [NUM_IRQ-1:0]  w_claim_clr;
    logic [NUM_IRQ-1:0]  w_pending_next;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_unused_data;

    // ready is high for the cycle after accept, which blocks a second accept back-to-back.
    assign w_accept = bus.select & ~r_ready;
    assign w_wr     = w_accept & (|bus.wstrb);
    assign w_rd     = w_accept & ~(|bus.wstrb);

    irq_prio_enc #(
        .N (NUM_IRQ)
    ) u_prio (
        .i_req  (r_pending & r_enable),
        .o_hit  (w_hit),
        .o_best (w_best)
    );

    assign w_claim    = w_rd && (bus.addr == REG_CLAIM) && (r_state == IDLE) && w_hit;
    assign w_complete = w_wr && (bus.addr == REG_COMPLETE) && (r_state == SERVICE)
                        && (bus.data_i[ID_W-1:0] == r_active_id);

    // Clears are applied before new edges are OR-ed in, so a fresh edge always survives.
    assign w_edge         = irq_src & ~r_src_q;
    assign w_w1c          = (w_wr && (bus.addr == REG_PENDING)) ? bus.data_i[NUM_IRQ-1:0] : '0;
    assign w_claim_clr    = w_claim ? (NUM_IRQ'(1) << w_best) : '0;
    assign w_pending_next = (r_pending & ~w_w1c & ~w_claim_clr) | w_edge;

    // Data bits above the implemented sources are don't-care on writes.
    assign w_unused_data = ^bus.data_i[DATA_W-1:NUM_IRQ];

    // Read data mux; CLAIM only returns a valid id when the claim actually takes effect.
    always_comb begin
        w_rdata = '0;
        case (bus.addr)
            REG_ENABLE:   w_rdata = DATA_W'(r_enable);
            REG_PENDING:  w_rdata = DATA_W'(r_pending);
            REG_CLAIM:    w_rdata = w_claim ? id_word(1'b1, w_best) : '0;
            REG_COMPLETE: w_rdata = id_word(r_state == SERVICE, r_active_id);
            default:      w_rdata = '0;
        endcase
    end

    // Bus handshake, edge detector and pending/enable registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready   <= 1'b0;
            r_data_o  <= '0;
            r_enable  <= '0;
            r_pending <= '0;
            r_src_q   <= '0;
        end else begin
            r_ready   <= w_accept;
            r_src_q   <= irq_src;
            r_pending <= w_pending_next;
            if (w_rd) begin
                r_data_o <= w_rdata;
            end
            if (w_wr && (bus.addr == REG_ENABLE)) begin
                r_enable <= bus.data_i[NUM_IRQ-1:0];
            end
        end
    end

    // Claim/complete state machine with the registered CPU interrupt line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_active_id <= '0;
            r_cpu_irq   <= 1'b0;
        end else begin
            r_cpu_irq <= (r_state == IDLE) && w_hit;
            case (r_state)
                IDLE: begin
                    if (w_claim) begin
                        r_active_id <= w_best;
                        r_state     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (w_complete) begin
                        r_active_id <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.data_o = r_data_o;
    assign cpu_irq    = r_cpu_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed and randomized checks of irq_ctrl against a register-level behavioural model.
module tb_irq_ctrl;

    logic       clk;
    logic       reset_n;
    logic [7:0] irq_src;
    logic       cpu_irq;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [7:0] m_pend;
    logic [7:0] m_en;
    bit         m_svc;
    int         m_id;

    irq_ctrl_if bus ();

    irq_ctrl #(
        .NUM_IRQ (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq_src (irq_src),
        .cpu_irq (cpu_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pend = '0;
        m_en   = '0;
        m_svc  = 1'b0;
        m_id   = 0;
    endfunction

    // One register access as the programmer sees it; edges land after any clear.
    function automatic logic [31:0] model_access(input bit wr, input logic [3:0] a,
                                                 input logic [31:0] wd, input logic [7:0] edges);
        logic [31:0] r;
        int          k;
        r = '0;
        k = -1;
        if (!wr) begin
            if (a == 4'h0) r = {24'h0, m_en};
            else if (a == 4'h4) r = {24'h0, m_pend};
            else if (a == 4'h8) begin
                if (!m_svc) begin
                    for (int i = 7; i >= 0; i--) if (m_pend[i] && m_en[i]) k = i;
                    if (k >= 0) begin
                        r         = 32'h8000_0000 | 32'(k);
                        m_pend[k] = 1'b0;
                        m_svc     = 1'b1;
                        m_id      = k;
                    end
                end
            end else if (a == 4'hC) begin
                r = (m_svc ? 32'h8000_0000 : 32'h0) | 32'(m_id);
            end
        end else begin
            if (a == 4'h0) m_en = wd[7:0];
            else if (a == 4'h4) m_pend = m_pend & ~wd[7:0];
            else if (a == 4'hC) begin
                if (m_svc && (wd[4:0] == 5'(m_id))) begin
                    m_svc = 1'b0;
                    m_id  = 0;
                end
            end
        end
        m_pend = m_pend | edges;
        return r;
    endfunction

    function automatic logic model_irq();
        return !m_svc && ((m_pend & m_en) != 8'h00);
    endfunction

    // Bus access with optional irq_src edges presented in the accept cycle.
    task automatic xfer(input bit wr, input logic [3:0] a, input logic [31:0] wd,
                        input logic [7:0] edges, output logic [31:0] rd);
        bit got;
        got = 1'b0;
        @(negedge clk);
        bus.select = 1'b1;
        bus.wstrb  = wr ? 4'hF : 4'h0;
        bus.addr   = a;
        bus.data_i = wd;
        irq_src    = edges;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            irq_src = '0;
            if (bus.ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        bus.select = 1'b0;
        rd = bus.data_o;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL ready_timeout addr=0x%h got=no-ready exp=ready within 8 cycles", a);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_width got=%b exp=0", bus.ready);
        end
        n_checks++;
        if (bus.data_o !== rd) begin
            n_fail++;
            $display("FAIL data_o_hold got=0x%h exp=0x%h", bus.data_o, rd);
        end
        $display("xfer %s addr=0x%h wdata=0x%h edges=0x%h rdata=0x%h cpu_irq=%b",
                 wr ? "WR" : "RD", a, wd, edges, rd, cpu_irq);
    endtask

    // Single-cycle pulse on irq_src; returns once cpu_irq has had time to follow.
    task automatic pulse(input logic [7:0] m);
        @(negedge clk);
        irq_src = m;
        @(negedge clk);
        irq_src = '0;
        m_pend  = m_pend | m;
        @(negedge clk);
        $display("pulse irq_src=0x%h cpu_irq=%b", m, cpu_irq);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp;
        reset_n    = 1'b0;
        irq_src    = '0;
        bus.select = 1'b0;
        bus.wstrb  = '0;
        bus.addr   = '0;
        bus.data_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cpu_irq !== 1'b0 || bus.ready !== 1'b0 || bus.data_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got=irq%b rdy%b do0x%h exp=0/0/0", cpu_irq, bus.ready, bus.data_o);
        end
        for (int r = 0; r < 4; r++) begin
            xfer(1'b0, 4'(r * 4), 32'h0, 8'h0, rd);
            exp = model_access(1'b0, 4'(r * 4), 32'h0, 8'h0);
            n_checks++;
            if (rd !== 32'h0 || exp !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read_0x%h got=0x%h exp=0x00000000", 4'(r * 4), rd);
            end
        end
        n_checks++;
        if (cpu_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cpu_irq got=%b exp=0", cpu_irq);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic [31:0] exp;
        xfer(1'b1, 4'h0, 32'h04, 8'h0, rd);
        exp = model_access(1'b1, 4'h0, 32'h04, 8'h0);
        pulse(8'h04);
        xfer(1'b0, 4'h4, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h4, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h04) begin n_fail++; $display("FAIL basic_pending got=0x%h exp=0x00000004", rd); end
        n_checks++;
        if (cpu_irq !== 1'b1) begin n_fail++; $display("FAIL basic_irq_high got=%b exp=1", cpu_irq); end
        xfer(1'b0, 4'h8, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h8, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h8000_0002) begin n_fail++; $display("FAIL basic_claim got=0x%h exp=0x80000002", rd); end
        xfer(1'b0, 4'h4, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h4, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL basic_pending_clr got=0x%h exp=0x00000000", rd); end
        n_checks++;
        if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL basic_irq_low got=%b exp=0", cpu_irq); end
        xfer(1'b1, 4'hC, 32'h2, 8'h0, rd);
        exp = model_access(1'b1, 4'hC, 32'h2, 8'h0);
        xfer(1'b0, 4'hC, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'hC, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL basic_complete_rd got=0x%h exp=0x00000000", rd); end
    endtask

    task automatic test_priority();
        logic [31:0] rd;
        logic [31:0] exp;
        xfer(1'b1, 4'h0, 32'hFF, 8'h0, rd);
        exp = model_access(1'b1, 4'h0, 32'hFF, 8'h0);
        pulse(8'h22);
        xfer(1'b0, 4'h8, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h8, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h8000_0001) begin n_fail++; $display("FAIL prio_claim1 got=0x%h exp=0x80000001", rd); end
        xfer(1'b0, 4'h8, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h8, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL prio_nested_claim got=0x%h exp=0x00000000", rd); end
        xfer(1'b1, 4'hC, 32'h1, 8'h0, rd);
        exp = model_access(1'b1, 4'hC, 32'h1, 8'h0);
        n_checks++;
        if (cpu_irq !== 1'b1) begin n_fail++; $display("FAIL prio_irq_after_c1 got=%b exp=1", cpu_irq); end
        xfer(1'b0, 4'h8, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h8, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h8000_0005) begin n_fail++; $display("FAIL prio_claim5 got=0x%h exp=0x80000005", rd); end
        xfer(1'b1, 4'hC, 32'h5, 8'h0, rd);
        exp = model_access(1'b1, 4'hC, 32'h5, 8'h0);
        n_checks++;
        if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL prio_irq_idle got=%b exp=0", cpu_irq); end
    endtask

    task automatic test_disabled();
        logic [31:0] rd;
        logic [31:0] exp;
        xfer(1'b1, 4'h0, 32'h00, 8'h0, rd);
        exp = model_access(1'b1, 4'h0, 32'h00, 8'h0);
        pulse(8'h08);
        xfer(1'b0, 4'h4, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h4, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h08) begin n_fail++; $display("FAIL dis_pending got=0x%h exp=0x00000008", rd); end
        n_checks++;
        if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL dis_irq_low got=%b exp=0", cpu_irq); end
        xfer(1'b1, 4'h0, 32'h08, 8'h0, rd);
        exp = model_access(1'b1, 4'h0, 32'h08, 8'h0);
        n_checks++;
        if (cpu_irq !== 1'b1) begin n_fail++; $display("FAIL dis_irq_enabled got=%b exp=1", cpu_irq); end
        xfer(1'b1, 4'h4, 32'h08, 8'h0, rd);
        exp = model_access(1'b1, 4'h4, 32'h08, 8'h0);
        n_checks++;
        if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL dis_irq_w1c got=%b exp=0", cpu_irq); end
        xfer(1'b0, 4'h4, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h4, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL dis_pending_w1c got=0x%h exp=0x00000000", rd); end
    endtask

    task automatic test_bad_complete();
        logic [31:0] rd;
        logic [31:0] exp;
        xfer(1'b1, 4'h0, 32'h10, 8'h0, rd);
        exp = model_access(1'b1, 4'h0, 32'h10, 8'h0);
        pulse(8'h10);
        xfer(1'b0, 4'h8, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h8, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h8000_0004) begin n_fail++; $display("FAIL badc_claim got=0x%h exp=0x80000004", rd); end
        xfer(1'b1, 4'hC, 32'h6, 8'h0, rd);
        exp = model_access(1'b1, 4'hC, 32'h6, 8'h0);
        xfer(1'b0, 4'hC, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'hC, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h8000_0004) begin n_fail++; $display("FAIL badc_still_svc got=0x%h exp=0x80000004", rd); end
        xfer(1'b1, 4'hC, 32'h4, 8'h0, rd);
        exp = model_access(1'b1, 4'hC, 32'h4, 8'h0);
        xfer(1'b0, 4'hC, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'hC, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL badc_idle got=0x%h exp=0x00000000", rd); end
    endtask

    task automatic test_claim_edge();
        logic [31:0] rd;
        logic [31:0] exp;
        xfer(1'b1, 4'h0, 32'h01, 8'h0, rd);
        exp = model_access(1'b1, 4'h0, 32'h01, 8'h0);
        pulse(8'h01);
        xfer(1'b0, 4'h8, 32'h0, 8'h01, rd);
        exp = model_access(1'b0, 4'h8, 32'h0, 8'h01);
        n_checks++;
        if (rd !== 32'h8000_0000) begin n_fail++; $display("FAIL cedge_claim got=0x%h exp=0x80000000", rd); end
        xfer(1'b0, 4'h4, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h4, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h01) begin n_fail++; $display("FAIL cedge_pending got=0x%h exp=0x00000001", rd); end
        n_checks++;
        if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL cedge_irq_svc got=%b exp=0", cpu_irq); end
        xfer(1'b1, 4'hC, 32'h0, 8'h0, rd);
        exp = model_access(1'b1, 4'hC, 32'h0, 8'h0);
        n_checks++;
        if (cpu_irq !== 1'b1) begin n_fail++; $display("FAIL cedge_irq_reassert got=%b exp=1", cpu_irq); end
    endtask

    task automatic test_reset_mid_service();
        logic [31:0] rd;
        logic [31:0] exp;
        xfer(1'b1, 4'h0, 32'h10, 8'h0, rd);
        exp = model_access(1'b1, 4'h0, 32'h10, 8'h0);
        pulse(8'h10);
        xfer(1'b0, 4'h8, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h8, 32'h0, 8'h0);
        @(negedge clk);
        reset_n = 1'b0;
        irq_src = 8'h02;
        #1;
        n_checks++;
        if (cpu_irq !== 1'b0) begin n_fail++; $display("FAIL rst_async_irq got=%b exp=0", cpu_irq); end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        m_pend  = 8'h02;
        @(negedge clk);
        irq_src = '0;
        xfer(1'b0, 4'h4, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h4, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h02) begin n_fail++; $display("FAIL rst_held_src_pending got=0x%h exp=0x00000002", rd); end
        xfer(1'b0, 4'hC, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'hC, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_svc_aborted got=0x%h exp=0x00000000", rd); end
        xfer(1'b0, 4'h0, 32'h0, 8'h0, rd);
        exp = model_access(1'b0, 4'h0, 32'h0, 8'h0);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_enable_clr got=0x%h exp=0x00000000", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] exp;
        logic [31:0] wd;
        logic [7:0]  edges;
        logic [3:0]  a;
        bit          wr;
        for (int n = 0; n < 300; n++) begin
            edges = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            wd    = $urandom;
            a     = 4'($urandom_range(0, 3) * 4);
            wr    = 1'b0;
            case ($urandom_range(0, 7))
                0: begin pulse(8'($urandom_range(1, 255))); continue; end
                1: begin wr = 1'b1; a = 4'h0; end
                2: begin wr = 1'b1; a = 4'h4; end
                3, 4: a = 4'h8;
                5: begin
                    wr = 1'b1;
                    a  = 4'hC;
                    wd = ($urandom_range(0, 1) == 1) ? 32'(m_id) : 32'($urandom_range(0, 31));
                end
                6: wr = 1'b0;
                default: wr = 1'b1;
            endcase
            xfer(wr, a, wd, edges, rd);
            exp = model_access(wr, a, wd, edges);
            if (!wr) begin
                n_checks++;
                if (rd !== exp) begin
                    n_fail++;
                    $display("FAIL rand_read_%0d addr=0x%h got=0x%h exp=0x%h", n, a, rd, exp);
                end
            end
            n_checks++;
            if (cpu_irq !== model_irq()) begin
                n_fail++;
                $display("FAIL rand_irq_%0d got=%b exp=%b", n, cpu_irq, model_irq());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_disabled();
        test_bad_complete();
        test_claim_edge();
        test_reset_mid_service();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
